multi_enabler: RTL and testbench

MULTI_ENABLER -- requirements
Module: multi_enabler

---
 rtl/multi_enabler_pkg.sv | 27 ++
 rtl/enabler_channel.sv | 133 +++++++++++++
 rtl/multi_enabler.sv | 36 +++
 tb/tb_multi_enabler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_enabler_pkg.sv
// Shared definitions for multi_enabler: channel FSM encoding, default parameters and wait-counter helpers.
// The divider is only built when MULTI_ENABLER_DIV_EN is defined.
package multi_enabler_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_SLEEP = 2'd3
    } chanState_e;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_DIV_W     = 4;
    localparam int DEF_WAKE_CYC  = 2;
    localparam int DEF_SLEEP_CYC = 3;

    // Wide enough for the largest wake/sleep count of 15.
    localparam int WAIT_W = 4;

    function automatic logic [WAIT_W-1:0] waitLoad(input int cycles);
        if (cycles > 0) begin
            return WAIT_W'(cycles - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/enabler_channel.sv
// One gated-clock channel: OFF/WAKE/ON/SLEEP sequencer, optional rate divider
// (MULTI_ENABLER_DIV_EN) and a low-phase latch that keeps the gated clock glitch-free.
module enabler_channel
    import multi_enabler_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int WAKE_CYC  = DEF_WAKE_CYC,
    parameter int SLEEP_CYC = DEF_SLEEP_CYC
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enb_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             eclk_o,
    output logic             ack_o,
    output logic             tick_o
);

    localparam logic [WAIT_W-1:0] WAKE_LOAD  = waitLoad(WAKE_CYC);
    localparam logic [WAIT_W-1:0] SLEEP_LOAD = waitLoad(SLEEP_CYC);

    chanState_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              g_q, g_d;
    logic              gateLat;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_OFF;
            wait_q  <= '0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_OFF: begin
                if (enb_i) begin
                    state_d = ST_WAKE;
                    wait_d  = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (!enb_i) begin
                    state_d = ST_OFF;
                end else if (wait_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_ON: begin
                if (!enb_i) begin
                    if (SLEEP_CYC == 0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_SLEEP;
                        wait_d  = SLEEP_LOAD;
                    end
                end
            end
            ST_SLEEP: begin
                if (enb_i) begin
                    state_d = ST_ON;
                end else if (wait_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                wait_d  = '0;
            end
        endcase
        g_d = (state_d == ST_ON) || (state_d == ST_SLEEP);
    end

    assign ack_o = g_q;

    // Reset is folded into the latch data so the gate is closed on the first low phase it is seen.
    always_latch begin
        if (!clk_i) begin
            gateLat = g_q & ~reset_i;
        end
    end

    assign eclk_o = clk_i & gateLat;

`ifdef MULTI_ENABLER_DIV_EN
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [DIV_W-1:0] divLim_q, divLim_d;
    logic [DIV_W-1:0] effLim;
    logic             tickHit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            divCnt_q <= '0;
            divLim_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
            divLim_q <= divLim_d;
        end
    end

    // The live divide value only matters at the start of a period; mid-period the held limit rules.
    always_comb begin
        effLim   = (divCnt_q == '0) ? div_i : divLim_q;
        tickHit  = g_q && (divCnt_q == effLim);
        divCnt_d = divCnt_q;
        divLim_d = divLim_q;
        if (!g_q) begin
            divCnt_d = '0;
        end else begin
            divLim_d = effLim;
            divCnt_d = tickHit ? '0 : divCnt_q + DIV_W'(1);
        end
    end

    assign tick_o = tickHit;
`else
    logic unusedDiv;
    assign unusedDiv = ^div_i;
    assign tick_o    = g_q;
`endif

endmodule

// File: rtl/multi_enabler.sv
// Top of the multi-channel clock enabler: CHANNELS independent enabler_channel instances.
// Define MULTI_ENABLER_DIV_EN to build the per-channel tick divider.
module multi_enabler
    import multi_enabler_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int WAKE_CYC  = DEF_WAKE_CYC,
    parameter int SLEEP_CYC = DEF_SLEEP_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enb,
    input  logic [CHANNELS*DIV_W-1:0] div,
    output logic [CHANNELS-1:0]       eclk,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS-1:0]       tick
);

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        enabler_channel #(
            .DIV_W    (DIV_W),
            .WAKE_CYC (WAKE_CYC),
            .SLEEP_CYC(SLEEP_CYC)
        ) uChan (
            .clk_i  (clk),
            .reset_i(reset),
            .enb_i  (enb[i]),
            .div_i  (div[i*DIV_W +: DIV_W]),
            .eclk_o (eclk[i]),
            .ack_o  (ack[i]),
            .tick_o (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_enabler.sv
// Self-checking bench for multi_enabler: hysteresis-style reference model plus directed literal checks.
// Tick expectations follow MULTI_ENABLER_DIV_EN the same way the design does.
module tb_multi_enabler;

    localparam int CH    = 4;
    localparam int DW    = 4;
    localparam int WAKE  = 2;
    localparam int SLEEP = 3;
    localparam int HALF  = 5;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     enb   = '1;
    logic [CH*DW-1:0]  div   = '0;
    logic [CH-1:0]     eclk;
    logic [CH-1:0]     ack;
    logic [CH-1:0]     tick;

    int testsRun    = 0;
    int testsFailed = 0;

    multi_enabler #(
        .CHANNELS (CH),
        .DIV_W    (DW),
        .WAKE_CYC (WAKE),
        .SLEEP_CYC(SLEEP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .enb  (enb),
        .div  (div),
        .eclk (eclk),
        .ack  (ack),
        .tick (tick)
    );

    always #HALF clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [CH-1:0] e, input logic [CH*DW-1:0] d);
        @(negedge clk);
        reset = r;
        enb   = e;
        div   = d;
    endtask

    task automatic sampleCycle();
        @(posedge clk);
        #3;
    endtask

    // Reference model: the gate opens after WAKE+1 consecutive sampled-high edges and
    // closes after SLEEP+1 consecutive sampled-low edges; the divider is a phase/limit pair.
    int highRun[CH];
    int lowRun[CH];
    bit gM[CH];
    bit gPrev[CH];
    int pos[CH];
    int lim[CH];

    function automatic bit modelTick(input int i, input logic [CH*DW-1:0] d);
        int dv;
        dv = int'(d[i*DW +: DW]);
`ifdef MULTI_ENABLER_DIV_EN
        if (!gM[i]) return 1'b0;
        return pos[i] == ((pos[i] == 0) ? dv : lim[i]);
`else
        if (dv < 0) return 1'b0;
        return gM[i];
`endif
    endfunction

    task automatic modelEdge(input logic r, input logic [CH-1:0] e, input logic [CH*DW-1:0] d);
        for (int i = 0; i < CH; i++) begin
            gPrev[i] = gM[i];
            if (r) begin
                highRun[i] = 0;
                lowRun[i]  = 0;
                gM[i]      = 1'b0;
                pos[i]     = 0;
                lim[i]     = 0;
            end else begin
                if (gM[i]) begin
                    bit t;
                    t = modelTick(i, d);
                    if (pos[i] == 0) lim[i] = int'(d[i*DW +: DW]);
                    pos[i] = t ? 0 : pos[i] + 1;
                end
                if (e[i]) begin
                    highRun[i]++;
                    lowRun[i] = 0;
                end else begin
                    lowRun[i]++;
                    highRun[i] = 0;
                end
                if (!gM[i] && highRun[i] >= WAKE + 1) gM[i] = 1'b1;
                else if (gM[i] && lowRun[i] >= SLEEP + 1) gM[i] = 1'b0;
                if (!gM[i]) pos[i] = 0;
            end
        end
    endtask

    // Compare process: model advances on each rising edge, outputs are checked in the high phase.
    initial begin : compareProc
        logic             rS;
        logic [CH-1:0]    eS;
        logic [CH*DW-1:0] dS;
        logic [CH-1:0]    ackExp, tickExp, eclkExp;
        for (int i = 0; i < CH; i++) begin
            highRun[i] = 0; lowRun[i] = 0; gM[i] = 0; gPrev[i] = 0; pos[i] = 0; lim[i] = 0;
        end
        forever begin
            @(posedge clk);
            rS = reset;
            eS = enb;
            dS = div;
            modelEdge(rS, eS, dS);
            #2;
            for (int i = 0; i < CH; i++) begin
                ackExp[i]  = gM[i];
                tickExp[i] = modelTick(i, dS);
                eclkExp[i] = gPrev[i] & ~rS;
            end
            checkOutput("model_ack", 32'(ack), 32'(ackExp));
            checkOutput("model_tick", 32'(tick), 32'(tickExp));
            checkOutput("model_eclk", 32'(eclk), 32'(eclkExp));
        end
    end

    // Every gated-clock pulse must be exactly one clk high phase wide.
    longint riseT[CH];
    logic [CH-1:0] eclkPrev = '0;
    always @(eclk) begin
        for (int i = 0; i < CH; i++) begin
            if (eclk[i] && !eclkPrev[i]) riseT[i] = longint'($time);
            if (!eclk[i] && eclkPrev[i]) begin
                checkOutput("eclk_pulse_width", 32'(longint'($time) - riseT[i]), 32'(HALF));
            end
        end
        eclkPrev = eclk;
    end

    localparam bit [6:0] DIV_PAT = 7'b1010100;

    initial begin : stimulusProc
        logic [CH*DW-1:0] dv;
        logic [CH-1:0]    e;
        bit               found;

        // Reset held with all requests high: everything stays closed.
        reset = 1'b1;
        enb   = '1;
        div   = '0;
        repeat (3) begin
            sampleCycle();
            checkOutput("reset_ack", 32'(ack), 32'h0);
            checkOutput("reset_tick", 32'(tick), 32'h0);
            checkOutput("reset_eclk", 32'(eclk), 32'h0);
        end
        applyStimulus(1'b0, '1, '0);
        sampleCycle();
        checkOutput("release_ack0_c1", 32'(ack[0]), 32'h0);
        sampleCycle();
        checkOutput("release_ack0_c2", 32'(ack[0]), 32'h0);
        sampleCycle();
        checkOutput("release_ack0_c3", 32'(ack[0]), 32'h1);
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b0, '0, '0);

        // Wake abort on channel 1.
        applyStimulus(1'b0, 4'b0010, '0);
        applyStimulus(1'b0, '0, '0);
        repeat (6) begin
            sampleCycle();
            checkOutput("abort_ack1", 32'(ack[1]), 32'h0);
            checkOutput("abort_eclk1", 32'(eclk[1]), 32'h0);
        end

        // Divider on channel 2: period 4, then div=1 mid-period.
        dv = '0;
        dv[2*DW +: DW] = DW'(3);
        applyStimulus(1'b0, 4'b0100, dv);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            sampleCycle();
            if (ack[2]) found = 1'b1;
        end
        checkOutput("div_ack2_rise", 32'(found), 32'h1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) sampleCycle();
`ifdef MULTI_ENABLER_DIV_EN
            checkOutput("div3_tick2", 32'(tick[2]), 32'((k % 4) == 3));
`else
            checkOutput("div3_tick2", 32'(tick[2]), 32'h1);
`endif
        end
        sampleCycle();
        dv[2*DW +: DW] = DW'(1);
        applyStimulus(1'b0, 4'b0100, dv);
        for (int k = 0; k < 7; k++) begin
            sampleCycle();
`ifdef MULTI_ENABLER_DIV_EN
            checkOutput("div1_tick2", 32'(tick[2]), 32'(DIV_PAT[k]));
`else
            checkOutput("div1_tick2", 32'(tick[2]), 32'h1);
`endif
        end
        applyStimulus(1'b0, '0, '0);
        repeat (6) sampleCycle();

        // Drain on channel 0, then re-assert during the second drain cycle.
        applyStimulus(1'b0, 4'b0001, '0);
        repeat (4) sampleCycle();
        checkOutput("drain_ack0_open", 32'(ack[0]), 32'h1);
        applyStimulus(1'b0, '0, '0);
        for (int s = 0; s < 5; s++) begin
            sampleCycle();
            checkOutput("drain_ack0", 32'(ack[0]), 32'(s < 3));
            checkOutput("drain_eclk0", 32'(eclk[0]), 32'(s < 4));
        end
        applyStimulus(1'b0, 4'b0001, '0);
        repeat (4) sampleCycle();
        applyStimulus(1'b0, '0, '0);
        sampleCycle();
        sampleCycle();
        applyStimulus(1'b0, 4'b0001, '0);
        repeat (6) begin
            sampleCycle();
            checkOutput("rearm_ack0", 32'(ack[0]), 32'h1);
            checkOutput("rearm_eclk0", 32'(eclk[0]), 32'h1);
        end
        applyStimulus(1'b0, '0, '0);
        repeat (6) sampleCycle();

        // Falling-edge toggling on every channel; pulse widths watched by the monitor.
        e = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(2) == 0) e[i] = ~e[i];
            end
            applyStimulus(1'b0, e, CH*DW'($urandom));
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(7) == 0) e[i] = ~e[i];
            end
            applyStimulus($urandom_range(63) == 0, e, CH*DW'($urandom));
        end

`ifndef MULTI_ENABLER_DIV_EN
        // Without the divider, tick follows ack even with the largest divide value.
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(5) == 0) e[i] = ~e[i];
            end
            applyStimulus(1'b0, e, '1);
            sampleCycle();
            checkOutput("nodiv_tick_eq_ack", 32'(tick), 32'(ack));
        end
`endif

        applyStimulus(1'b0, '0, '0);
        repeat (8) sampleCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
